watch_timekeeper: RTL and testbench

Timekeeping core of the watch chip. It holds the time-of-day counter and the stopwatch counter, both as binary hours/minutes/seconds, and advances them from a 1 Hz tick. Its behaviour is steered by the 3-bit mode code from watch_fsm. Its six 6-bit outputs feed Seg7Display directly, as current_s/m/h and stopwatch_s/m/h, along with a colon-blink flag.

---
 rtl/watch_pkg.sv | 36 +++
 rtl/hms_counter.sv | 69 ++++++
 rtl/watch_timekeeper.sv | 87 ++++++++
 tb/tb_watch_timekeeper.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared mode encodings and default counter limits for the watch chip.
// Also holds the mode-decode helpers used by the timekeeper.
package watch_pkg;

  localparam logic [2:0] HIDE_STOPPED = 3'b000;
  localparam logic [2:0] SET_H        = 3'b001;
  localparam logic [2:0] SET_M        = 3'b010;
  localparam logic [2:0] SHOW_STOPPED = 3'b011;
  localparam logic [2:0] SHOW_RUNNING = 3'b100;
  localparam logic [2:0] SW_RESET     = 3'b101;
  localparam logic [2:0] HIDE_RUNNING = 3'b110;

  localparam int SEC_MAX_DEF  = 59;
  localparam int HOUR_MAX_DEF = 23;

  // Time of day runs in every legal mode except the two SET modes.
  function automatic logic todRuns(input logic [2:0] st);
    logic r;
    r = 1'b0;
    case (st)
      HIDE_STOPPED, SHOW_STOPPED, SHOW_RUNNING,
      SW_RESET, HIDE_RUNNING: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic swRuns(input logic [2:0] st);
    return (st == SHOW_RUNNING) || (st == HIDE_RUNNING);
  endfunction

  function automatic logic isSetState(input logic [2:0] st);
    return (st == SET_H) || (st == SET_M);
  endfunction

endpackage

// File: rtl/hms_counter.sv
// Binary hours/minutes/seconds counter with tick, clear, per-field
// increment and seconds clear; pulses wrap on a full rollover.
module hms_counter #(
  parameter int SEC_MAX  = 59,
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       inc_h,
  input  logic       inc_m,
  input  logic       clr_s,
  output logic [5:0] s,
  output logic [5:0] m,
  output logic [5:0] h,
  output logic       wrap
);

  localparam logic [5:0] S_TOP = 6'(SEC_MAX);
  localparam logic [5:0] H_TOP = 6'(HOUR_MAX);

  logic sTop;
  logic mTop;
  logic hTop;

  assign sTop = (s == S_TOP);
  assign mTop = (m == S_TOP);
  assign hTop = (h == H_TOP);

  // Manual edits take precedence over the tick; the top never asserts both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      m    <= '0;
      h    <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        s <= '0;
        m <= '0;
        h <= '0;
      end else if (inc_h || inc_m || clr_s) begin
        if (inc_h) h <= hTop ? 6'd0 : h + 6'd1;
        if (inc_m) m <= mTop ? 6'd0 : m + 6'd1;
        if (clr_s) s <= '0;
      end else if (en) begin
        if (sTop) begin
          s <= '0;
          if (mTop) begin
            m <= '0;
            if (hTop) begin
              h    <= '0;
              wrap <= 1'b1;
            end else begin
              h <= h + 6'd1;
            end
          end else begin
            m <= m + 6'd1;
          end
        end else begin
          s <= s + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/watch_timekeeper.sv
// Time-of-day and stopwatch counters steered by the watch_fsm mode code,
// plus the colon-blink flag.
module watch_timekeeper
  import watch_pkg::*;
#(
  parameter int SEC_MAX  = SEC_MAX_DEF,
  parameter int HOUR_MAX = HOUR_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seconds_clk,
  input  logic [2:0] state,
  input  logic       inc,
  output logic [5:0] current_s,
  output logic [5:0] current_m,
  output logic [5:0] current_h,
  output logic [5:0] stopwatch_s,
  output logic [5:0] stopwatch_m,
  output logic [5:0] stopwatch_h,
  output logic       second,
  output logic       sw_wrap
);

  logic setNow;
  logic setPrev;
  logic setEntry;
  logic todEn;
  logic swEn;
  logic swClr;
  logic incH;
  logic incM;
  logic todWrapUnused;

  assign setNow   = isSetState(state);
  assign setEntry = setNow & ~setPrev;
  assign todEn    = seconds_clk & todRuns(state);
  assign swEn     = seconds_clk & swRuns(state);
  assign swClr    = (state == SW_RESET);
  assign incH     = inc & (state == SET_H);
  assign incM     = inc & (state == SET_M);

  // Seconds are cleared only on the edge into SET, not between SET_H and SET_M.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) setPrev <= 1'b0;
    else        setPrev <= setNow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           second <= 1'b0;
    else if (seconds_clk) second <= ~second;
  end

  hms_counter #(
    .SEC_MAX (SEC_MAX),
    .HOUR_MAX(HOUR_MAX)
  ) todCounter (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (todEn),
    .clr  (1'b0),
    .inc_h(incH),
    .inc_m(incM),
    .clr_s(setEntry),
    .s    (current_s),
    .m    (current_m),
    .h    (current_h),
    .wrap (todWrapUnused)
  );

  hms_counter #(
    .SEC_MAX (SEC_MAX),
    .HOUR_MAX(HOUR_MAX)
  ) swCounter (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (swEn),
    .clr  (swClr),
    .inc_h(1'b0),
    .inc_m(1'b0),
    .clr_s(1'b0),
    .s    (stopwatch_s),
    .m    (stopwatch_m),
    .h    (stopwatch_h),
    .wrap (sw_wrap)
  );

endmodule

// File: tb/tb_watch_timekeeper.sv
// Directed bench for watch_timekeeper, built with reduced limits
// (seconds/minutes 0..9, hours 0..3) so full rollovers stay short.
module tb_watch_timekeeper;
  import watch_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       seconds_clk = 1'b0;
  logic [2:0] state = HIDE_STOPPED;
  logic       inc = 1'b0;
  logic [5:0] current_s, current_m, current_h;
  logic [5:0] stopwatch_s, stopwatch_m, stopwatch_h;
  logic       second;
  logic       sw_wrap;

  int nCmp = 0;
  int nErr = 0;

  watch_timekeeper #(
    .SEC_MAX (9),
    .HOUR_MAX(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seconds_clk(seconds_clk),
    .state      (state),
    .inc        (inc),
    .current_s  (current_s),
    .current_m  (current_m),
    .current_h  (current_h),
    .stopwatch_s(stopwatch_s),
    .stopwatch_m(stopwatch_m),
    .stopwatch_h(stopwatch_h),
    .second     (second),
    .sw_wrap    (sw_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkHms(input string tag, input logic [5:0] oh, input logic [5:0] om,
                        input logic [5:0] os, input int eh, input int em, input int es);
    nCmp++;
    assert ({oh, om, os} === {6'(eh), 6'(em), 6'(es)}) else begin
      nErr++;
      $error("FAIL %s: observed %0d:%0d:%0d expected %0d:%0d:%0d", tag, oh, om, os, eh, em, es);
    end
  endtask

  task automatic chkCur(input string tag, input int eh, input int em, input int es);
    chkHms(tag, current_h, current_m, current_s, eh, em, es);
  endtask

  task automatic chkSw(input string tag, input int eh, input int em, input int es);
    chkHms(tag, stopwatch_h, stopwatch_m, stopwatch_s, eh, em, es);
  endtask

  // Hold seconds_clk/inc for n consecutive edges, then return at a quiet negedge.
  task automatic drive(input int n, input logic s, input logic i);
    repeat (n) begin
      @(negedge clk);
      seconds_clk = s;
      inc = i;
    end
    @(negedge clk);
    seconds_clk = 1'b0;
    inc = 1'b0;
  endtask

  task automatic goState(input logic [2:0] st);
    @(negedge clk);
    state = st;
    @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chkCur("reset_cur", 0, 0, 0);
    chkSw("reset_sw", 0, 0, 0);
    chk("reset_second", 32'(second), 0);
    chk("reset_wrap", 32'(sw_wrap), 0);
    rst_n = 1'b1;

    drive(111, 1'b1, 1'b0);
    chkCur("run111_cur", 1, 1, 1);
    chkSw("run111_sw", 0, 0, 0);
    chk("run111_second", 32'(second), 1);

    goState(SET_H);
    chkCur("seth_entry_clr", 1, 1, 0);
    drive(5, 1'b0, 1'b1);
    chkCur("seth_inc5_wrap", 2, 1, 0);
    drive(1, 1'b1, 1'b0);
    chkCur("seth_tick_frozen", 2, 1, 0);
    chk("seth_tick_second", 32'(second), 0);

    goState(SET_M);
    drive(11, 1'b0, 1'b1);
    chkCur("setm_inc11_nocarry", 2, 2, 0);
    drive(1, 1'b1, 1'b1);
    chkCur("setm_inc_and_tick", 2, 3, 0);
    chk("setm_second", 32'(second), 1);

    goState(SET_H);
    drive(1, 1'b0, 1'b1);
    goState(SET_M);
    drive(6, 1'b0, 1'b1);
    chkCur("preload_hm", 3, 9, 0);
    goState(HIDE_STOPPED);
    drive(8, 1'b1, 1'b0);
    chkCur("preload_full", 3, 9, 8);
    drive(1, 1'b1, 1'b0);
    chkCur("tod_max", 3, 9, 9);
    drive(1, 1'b1, 1'b0);
    chkCur("tod_wrap", 0, 0, 0);
    chk("tod_wrap_second", 32'(second), 1);
    chkSw("sw_held_000", 0, 0, 0);
    chk("no_sw_wrap_tod", 32'(sw_wrap), 0);
    drive(2, 1'b0, 1'b1);
    chkCur("inc_ignored_000", 0, 0, 0);

    goState(SHOW_RUNNING);
    drive(399, 1'b1, 1'b0);
    chkSw("sw_max", 3, 9, 9);
    chk("sw_wrap_before", 32'(sw_wrap), 0);
    chkCur("cur_during_sw", 3, 9, 9);
    drive(1, 1'b1, 1'b0);
    chkSw("sw_rollover", 0, 0, 0);
    chk("sw_wrap_pulse", 32'(sw_wrap), 1);
    chk("sw_wrap_second", 32'(second), 1);
    @(negedge clk);
    chk("sw_wrap_one_cycle", 32'(sw_wrap), 0);

    drive(57, 1'b1, 1'b0);
    chkSw("sw_057", 0, 5, 7);
    @(negedge clk);
    state = SW_RESET;
    seconds_clk = 1'b1;
    @(negedge clk);
    seconds_clk = 1'b0;
    chkSw("swreset_coincident", 0, 0, 0);
    chkCur("swreset_cur_runs", 0, 5, 8);
    drive(3, 1'b1, 1'b0);
    chkSw("swreset_stays0", 0, 0, 0);
    chkCur("swreset_cur_061", 0, 6, 1);
    chk("swreset_second", 32'(second), 0);

    goState(HIDE_RUNNING);
    drive(2, 1'b1, 1'b0);
    chkSw("hide_running_sw", 0, 0, 2);
    goState(SHOW_STOPPED);
    drive(2, 1'b1, 1'b0);
    chkSw("show_stopped_hold", 0, 0, 2);
    chkCur("show_stopped_cur", 0, 6, 5);

    goState(3'b111);
    drive(3, 1'b1, 1'b1);
    chkCur("illegal_cur_hold", 0, 6, 5);
    chkSw("illegal_sw_hold", 0, 0, 2);
    chk("illegal_second_toggles", 32'(second), 1);
    goState(HIDE_STOPPED);
    drive(1, 1'b1, 1'b0);
    chkCur("resume_after_illegal", 0, 6, 6);

    @(negedge clk);
    seconds_clk = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chkCur("async_rst_cur", 0, 0, 0);
    chkSw("async_rst_sw", 0, 0, 0);
    chk("async_rst_second", 32'(second), 0);
    @(negedge clk);
    seconds_clk = 1'b0;
    @(posedge clk);
    #1;
    chkCur("rst_held_cur", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1'b1, 1'b0);
    chkCur("post_rst_tick", 0, 0, 1);
    chk("post_rst_second", 32'(second), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
